// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   DATA_WIDTH    : default datapath width
//   RESET_PC      : default PC loaded on reset
//   INSTR_BYTES   : size of one instruction word in bytes (sequential PC step)
//   WAIT_LIMIT    : default number of WAIT cycles before a fetch times out
package fetch_pkg;

    localparam int          DATA_WIDTH  = 32;
    localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
    localparam int          INSTR_BYTES = 4;
    localparam int          WAIT_LIMIT  = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC computation for the fetch stage (purely combinational).
//   pc         in  : address of the held instruction
//   ImmOp      in  : sign-extended branch offset
//   PCsrc      in  : 1 = branch taken, use pc + ImmOp
//   next       out : candidate next PC (wraps modulo 2^DATA_WIDTH)
//   misaligned out : next is not on an instruction-word boundary
module pc_next
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = fetch_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic                  PCsrc,
    output logic [DATA_WIDTH-1:0] next,
    output logic                  misaligned
);

    assign next       = PCsrc ? (pc + ImmOp) : (pc + DATA_WIDTH'(INSTR_BYTES));
    assign misaligned = (next[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request per instruction to
// instruction memory, holds the returned word until downstream accepts it,
// then steps the PC sequentially or by the branch offset.
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   imem_req / imem_addr  : level request and address, held until imem_valid
//   imem_rdata/imem_valid : returned word and its strobe (used only in WAIT)
//   stall                 : downstream not ready, keep the held instruction
//   PCsrc / ImmOp         : branch decision and offset for the held instruction
//   instr / instr_valid   : held instruction word for the decoder
//   pc                    : address of held instruction / current fetch
//   fetch_err             : sticky timeout or misaligned-target error
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = fetch_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int                    WAIT_LIMIT = fetch_pkg::WAIT_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_valid,
    input  logic                  stall,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  fetch_err
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    fetch_state_t          state, state_nx;
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  next_misaligned;
    logic                  wait_expired;

    pc_next #(.DATA_WIDTH(DATA_WIDTH)) u_pc_next (
        .pc         (pc),
        .ImmOp      (ImmOp),
        .PCsrc      (PCsrc),
        .next       (next_pc),
        .misaligned (next_misaligned)
    );

    // Last permitted WAIT cycle: the counter holds the number of WAIT cycles
    // already spent without a response.
    assign wait_expired = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = FETCH;
            FETCH: state_nx = WAIT;
            WAIT: begin
                // A response in the final cycle still wins over the timeout.
                if (imem_valid)        state_nx = HOLD;
                else if (wait_expired) state_nx = ERR;
            end
            HOLD: begin
                if (!stall) state_nx = next_misaligned ? ERR : FETCH;
            end
            ERR:     state_nx = ERR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            instr     <= '0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            unique case (state)
                FETCH: wait_cnt <= '0;
                WAIT: begin
                    if (imem_valid)        instr     <= imem_rdata;
                    else if (wait_expired) fetch_err <= 1'b1;
                    else                   wait_cnt  <= wait_cnt + 1'b1;
                end
                HOLD: begin
                    if (!stall) begin
                        if (next_misaligned) fetch_err <= 1'b1;
                        else                 pc        <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request and valid are decoded from the state register, so an
    // asynchronous reset drops imem_req in the same cycle it is asserted.
    assign imem_req    = (state == FETCH) || (state == WAIT);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

endmodule
